// File: rtl/cache_pkg.sv
// Shared definitions for the parametrised cache block fill controller:
// FSM state encoding, a constant-friendly ceil-log2 helper and the
// offset/counter widths that correspond to the default geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } fill_state_e;

  // Ceil-log2 usable in parameter/localparam elaboration.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_WORD_BYTES  = 2;
  localparam int DEF_BLOCK_WORDS = 8;
  localparam int OFF_W           = clog2(DEF_WORD_BYTES * DEF_BLOCK_WORDS);
  localparam int CNT_W           = clog2(DEF_BLOCK_WORDS) + 1;

endpackage

// File: rtl/cache_fill_ctrl_p_if.sv
// Bus between the fill controller, the tag-match stage, main memory and
// the data/tag arrays. The master side is the fill controller itself.
interface cache_fill_ctrl_p_if #(
  parameter int ADDR_W = cache_pkg::DEF_ADDR_W,
  parameter int OFF_W  = cache_pkg::OFF_W
) ();

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_addr;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              write_data_array;
  logic [OFF_W-1:0]  cache_write_block_offset;
  logic              write_tag_array;
  logic [ADDR_W-1:0] base_addr;
  logic              critical_ready;

  modport master (
    input  miss_detected, miss_addr, memory_data_valid,
    output fsm_busy, mem_read, mem_read_addr, write_data_array,
           cache_write_block_offset, write_tag_array, base_addr, critical_ready
  );

  modport slave (
    output miss_detected, miss_addr, memory_data_valid,
    input  fsm_busy, mem_read, mem_read_addr, write_data_array,
           cache_write_block_offset, write_tag_array, base_addr, critical_ready
  );

endinterface

// File: rtl/cache_fill_wrap_ctr.sv
// Word counter for one side of a block fill (issue or write). Counts
// 0..BLOCK_WORDS and maps the count onto a word index that wraps inside the
// block, starting at start_word.
module cache_fill_wrap_ctr
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         inc,
  input  logic [clog2(BLOCK_WORDS)-1:0] start_word,
  output logic [clog2(BLOCK_WORDS):0]   count,
  output logic [clog2(BLOCK_WORDS)-1:0] word_idx
);

  localparam int IDX_W    = clog2(BLOCK_WORDS);
  localparam int CNT_BITS = IDX_W + 1;

  logic [CNT_BITS-1:0] count_r;

  // Count words handled in this fill; saturate at a full block.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_BITS{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_BITS{1'b0}};
    end else if (inc && (count_r < CNT_BITS'(BLOCK_WORDS))) begin
      count_r <= count_r + CNT_BITS'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Power-of-two block: dropping the carry is the modulo-BLOCK_WORDS wrap.
  assign word_idx = start_word + count_r[IDX_W-1:0];
  assign count    = count_r;

endmodule

// File: rtl/cache_fill_ctrl_p.sv
// Cache block fill controller: on a miss it issues one read per block word,
// streams returning words into the data array (optionally critical word
// first), then commits the tag/valid bit in a dedicated one-cycle state.
module cache_fill_ctrl_p
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WORD_BYTES  = 2,
  parameter int BLOCK_WORDS = 8,
  parameter int CWF         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_fill_ctrl_p_if.master  bus
);

  localparam int WB_W     = clog2(WORD_BYTES);
  localparam int IDX_W    = clog2(BLOCK_WORDS);
  localparam int OFF_BITS = clog2(WORD_BYTES * BLOCK_WORDS);
  localparam int CNT_BITS = IDX_W + 1;

  fill_state_e         state_r;
  fill_state_e         next_state_s;
  logic [ADDR_W-1:0]   base_addr_r;
  logic [IDX_W-1:0]    start_word_r;
  logic [IDX_W-1:0]    crit_word_r;
  logic [IDX_W-1:0]    miss_word_s;
  logic [CNT_BITS-1:0] issued_s;
  logic [CNT_BITS-1:0] returned_s;
  logic [IDX_W-1:0]    issue_idx_s;
  logic [IDX_W-1:0]    write_idx_s;
  logic                accept_miss_s;
  logic                busy_s;
  logic                fill_s;
  logic                wr_en_s;
  logic                commit_s;
  logic                last_issue_s;
  logic                last_write_s;
  logic                crit_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [OFF_BITS-1:0] wr_off_s;

  // Word index of the missed byte within its block.
  assign miss_word_s = IDX_W'(bus.miss_addr[OFF_BITS-1:0] >> WB_W);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; the final write wins over the final issue so a
  // zero-drain fill goes straight from FILL to COMMIT.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_miss_s) begin
          next_state_s = ST_FILL;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (last_write_s) begin
          next_state_s = ST_COMMIT;
        end else if (last_issue_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (last_write_s) begin
          next_state_s = ST_COMMIT;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output and control decode from the current state.
  always_comb begin
    accept_miss_s = 1'b0;
    busy_s        = 1'b0;
    fill_s        = 1'b0;
    wr_en_s       = 1'b0;
    commit_s      = 1'b0;
    case (state_r)
      ST_IDLE:   accept_miss_s = bus.miss_detected;
      ST_FILL: begin
        busy_s  = 1'b1;
        fill_s  = 1'b1;
        wr_en_s = bus.memory_data_valid;
      end
      ST_DRAIN: begin
        busy_s  = 1'b1;
        wr_en_s = bus.memory_data_valid;
      end
      ST_COMMIT: begin
        busy_s   = 1'b1;
        commit_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase

    last_issue_s = fill_s  & (issued_s   == CNT_BITS'(BLOCK_WORDS - 1));
    last_write_s = wr_en_s & (returned_s == CNT_BITS'(BLOCK_WORDS - 1));

    if (fill_s) begin
      rd_addr_s = base_addr_r | (ADDR_W'(issue_idx_s) << WB_W);
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end

    if (wr_en_s) begin
      wr_off_s = OFF_BITS'(write_idx_s) << WB_W;
      crit_s   = (write_idx_s == crit_word_r);
    end else begin
      wr_off_s = {OFF_BITS{1'b0}};
      crit_s   = 1'b0;
    end
  end

  // Miss context is captured only when a fill is accepted and held until
  // the next accepted miss, so misses seen while busy cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr_r  <= {ADDR_W{1'b0}};
      start_word_r <= {IDX_W{1'b0}};
      crit_word_r  <= {IDX_W{1'b0}};
    end else if (accept_miss_s) begin
      base_addr_r  <= {bus.miss_addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
      start_word_r <= (CWF != 0) ? miss_word_s : {IDX_W{1'b0}};
      crit_word_r  <= miss_word_s;
    end else begin
      base_addr_r  <= base_addr_r;
      start_word_r <= start_word_r;
      crit_word_r  <= crit_word_r;
    end
  end

  cache_fill_wrap_ctr #(.BLOCK_WORDS(BLOCK_WORDS)) u_issue_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (commit_s),
    .inc        (fill_s),
    .start_word (start_word_r),
    .count      (issued_s),
    .word_idx   (issue_idx_s)
  );

  cache_fill_wrap_ctr #(.BLOCK_WORDS(BLOCK_WORDS)) u_write_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (commit_s),
    .inc        (wr_en_s),
    .start_word (start_word_r),
    .count      (returned_s),
    .word_idx   (write_idx_s)
  );

  assign bus.fsm_busy                 = busy_s;
  assign bus.mem_read                 = fill_s;
  assign bus.mem_read_addr            = rd_addr_s;
  assign bus.write_data_array         = wr_en_s;
  assign bus.cache_write_block_offset = wr_off_s;
  assign bus.write_tag_array          = commit_s;
  assign bus.base_addr                = base_addr_r;
  assign bus.critical_ready           = crit_s;

endmodule

// File: tb/tb_cache_fill_ctrl_p.sv
// Directed bench for cache_fill_ctrl_p: three geometries, a latency model
// for main memory and a scoreboard of expected read addresses and write
// offsets built from the miss address.
module tb_cache_fill_ctrl_p;

  logic clk;
  logic rst;

  cache_fill_ctrl_p_if #(.ADDR_W(16), .OFF_W(4)) if0 ();
  cache_fill_ctrl_p_if #(.ADDR_W(16), .OFF_W(4)) if1 ();
  cache_fill_ctrl_p_if #(.ADDR_W(16), .OFF_W(4)) if2 ();

  cache_fill_ctrl_p #(.ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8), .CWF(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  cache_fill_ctrl_p #(.ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8), .CWF(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  cache_fill_ctrl_p #(.ADDR_W(16), .WORD_BYTES(4), .BLOCK_WORDS(4), .CWF(0)) dut2 (
    .clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_rd_q[$];
  logic [15:0] exp_wr_q[$];
  int          due_q[$];

  logic        s_busy, s_rd, s_wr, s_tag, s_crit;
  logic [15:0] s_rd_addr, s_base;
  logic [3:0]  s_off;

  int g_tag_cyc, g_first_crit, g_drain;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_miss(input int sel, input logic m, input logic [15:0] a);
    case (sel)
      0: begin if0.miss_detected = m; if0.miss_addr = a; end
      1: begin if1.miss_detected = m; if1.miss_addr = a; end
      default: begin if2.miss_detected = m; if2.miss_addr = a; end
    endcase
  endtask

  task automatic drive_valid(input int sel, input logic v);
    case (sel)
      0: if0.memory_data_valid = v;
      1: if1.memory_data_valid = v;
      default: if2.memory_data_valid = v;
    endcase
  endtask

  task automatic sample(input int sel);
    case (sel)
      0: begin
        s_busy = if0.fsm_busy; s_rd = if0.mem_read; s_rd_addr = if0.mem_read_addr;
        s_wr = if0.write_data_array; s_off = if0.cache_write_block_offset;
        s_tag = if0.write_tag_array; s_base = if0.base_addr; s_crit = if0.critical_ready;
      end
      1: begin
        s_busy = if1.fsm_busy; s_rd = if1.mem_read; s_rd_addr = if1.mem_read_addr;
        s_wr = if1.write_data_array; s_off = if1.cache_write_block_offset;
        s_tag = if1.write_tag_array; s_base = if1.base_addr; s_crit = if1.critical_ready;
      end
      default: begin
        s_busy = if2.fsm_busy; s_rd = if2.mem_read; s_rd_addr = if2.mem_read_addr;
        s_wr = if2.write_data_array; s_off = if2.cache_write_block_offset;
        s_tag = if2.write_tag_array; s_base = if2.base_addr; s_crit = if2.critical_ready;
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(s_busy), 32'd0);
    check({tag, "_rd"},   32'(s_rd), 32'd0);
    check({tag, "_rdad"}, 32'(s_rd_addr), 32'd0);
    check({tag, "_wr"},   32'(s_wr), 32'd0);
    check({tag, "_off"},  32'(s_off), 32'd0);
    check({tag, "_tag"},  32'(s_tag), 32'd0);
    check({tag, "_base"}, 32'(s_base), 32'd0);
    check({tag, "_crit"}, 32'(s_crit), 32'd0);
  endtask

  // One fill, starting at posedge+1 of cycle 0 (the cycle the miss is
  // presented). lat: read at cycle c returns at c+lat-1. gap: returns only
  // on every third cycle. disturb: foreign miss at cycle 3 and in COMMIT.
  // abort_at: assert rst after that many writes.
  task automatic run_fill(input int sel, input logic [15:0] addr, input int wb, input int bw,
                          input int cwf, input int lat, input int gap, input int disturb,
                          input int abort_at);
    int blk, off, crit, start, idx, cyc, nrd, nwr, ntag, last_wr, low_cyc, drain;
    int first_crit, crit_off;
    logic [15:0] base_exp, e;
    logic done, seen_busy, v;
    blk = wb * bw; off = int'(addr) % blk; crit = off / wb;
    start = (cwf != 0) ? crit : 0;
    base_exp = addr - 16'(off);
    crit_off = crit * wb;
    for (int k = 0; k < bw; k++) begin
      idx = (start + k) % bw;
      exp_rd_q.push_back(base_exp + 16'(idx * wb));
      exp_wr_q.push_back(16'(idx * wb));
    end
    cyc = 0; nrd = 0; nwr = 0; ntag = 0; last_wr = -1; low_cyc = -1; drain = 0;
    first_crit = -1; done = 1'b0; seen_busy = 1'b0;
    while (!done && cyc < 200) begin
      if (cyc == 0) drive_miss(sel, 1'b1, addr);
      else if (disturb != 0 && (cyc == 3 || cyc == bw + lat)) drive_miss(sel, 1'b1, 16'h7770);
      else drive_miss(sel, 1'b0, addr);
      v = 1'b0;
      if (due_q.size() > 0) begin
        if (due_q[0] <= cyc && (gap == 0 || cyc % 3 == 0)) begin
          v = 1'b1;
          void'(due_q.pop_front());
        end
      end
      drive_valid(sel, v);
      @(negedge clk);
      sample(sel);
      if (s_rd) begin
        check("rd_cycle", 32'(cyc), 32'(nrd + 1));
        if (exp_rd_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
        else begin e = exp_rd_q.pop_front(); check("rd_addr", 32'(s_rd_addr), 32'(e)); end
        due_q.push_back(cyc + lat - 1);
        nrd++;
      end
      if (s_wr) begin
        if (exp_wr_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
        else begin
          e = exp_wr_q.pop_front();
          check("wr_off", 32'(s_off), 32'(e));
          check("crit_rdy", 32'(s_crit), (int'(e) == crit_off) ? 32'd1 : 32'd0);
        end
        if (nwr == 0) first_crit = int'(s_crit);
        nwr++; last_wr = cyc;
        if (abort_at != 0 && nwr == abort_at) begin rst = 1'b1; done = 1'b1; end
      end
      if (s_tag) begin ntag++; g_tag_cyc = cyc; end
      if (s_busy) begin
        seen_busy = 1'b1;
        check("base_addr", 32'(s_base), 32'(base_exp));
        if (!s_rd && !s_wr && !s_tag) drain++;
      end
      if (seen_busy && !s_busy) begin low_cyc = cyc; done = 1'b1; end
      @(posedge clk); #1;
      cyc++;
    end
    drive_miss(sel, 1'b0, addr);
    drive_valid(sel, 1'b0);
    if (!done) check("timeout", 32'd0, 32'd1);
    if (abort_at == 0) begin
      check("n_reads", 32'(nrd), 32'(bw));
      check("n_writes", 32'(nwr), 32'(bw));
      check("n_tag", 32'(ntag), 32'd1);
      check("tag_after_wr", 32'(g_tag_cyc), 32'(last_wr + 1));
      check("busy_low", 32'(low_cyc), 32'(g_tag_cyc + 1));
      check("sb_empty", 32'(exp_rd_q.size() + exp_wr_q.size()), 32'd0);
    end
    g_first_crit = first_crit;
    g_drain = drain;
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin drive_miss(s, 1'b0, 16'h0000); drive_valid(s, 1'b0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(0); check_all_zero("rst0");
    sample(1); check("rst1_busy", 32'(s_busy), 32'd0);
    sample(2); check("rst2_busy", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fill, 4-cycle memory.
    run_fill(0, 16'h1236, 2, 8, 0, 4, 0, 0, 0);
    check("t1_tag_cycle", 32'(g_tag_cyc), 32'd12);
    @(posedge clk); #1;

    // Critical word first with wrap E -> 0.
    run_fill(1, 16'h123A, 2, 8, 1, 4, 0, 0, 0);
    check("t2_first_crit", 32'(g_first_crit), 32'd1);
    @(posedge clk); #1;

    // Gapped returns hold the controller in DRAIN.
    run_fill(0, 16'h2004, 2, 8, 0, 4, 1, 0, 0);
    check("t3_drain_seen", (g_drain > 0) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;

    // Foreign misses mid-FILL and in COMMIT are ignored.
    run_fill(0, 16'h4552, 2, 8, 0, 4, 0, 1, 0);
    @(negedge clk); sample(0);
    check("t4_idle_busy", 32'(s_busy), 32'd0);
    check("t4_idle_rd", 32'(s_rd), 32'd0);
    @(posedge clk); #1;

    // Reset at the third write, then late valids.
    run_fill(0, 16'h1236, 2, 8, 0, 4, 0, 0, 3);
    drive_valid(0, 1'b1);
    @(negedge clk); sample(0); check_all_zero("t5_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sample(0);
      check("t5_late_wr", 32'(s_wr), 32'd0);
      check("t5_late_busy", 32'(s_busy), 32'd0);
      @(posedge clk); #1;
    end
    drive_valid(0, 1'b0);
    exp_rd_q.delete(); exp_wr_q.delete(); due_q.delete();
    run_fill(0, 16'h3330, 2, 8, 0, 4, 0, 0, 0);
    @(posedge clk); #1;

    // 4-byte words, 4-word blocks.
    run_fill(2, 16'h00F8, 4, 4, 0, 4, 0, 0, 0);
    check("t6_tag_cycle", 32'(g_tag_cyc), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
